// File: rtl/floo_pkg.sv
// Shared router types for the FlooNoC VC router.
// Holds the credit-counter update opcode and its decode helper.
package floo_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // A simultaneous credit return and consume cancel out.
  function automatic cnt_op_e cnt_op(
    input logic inc,
    input logic dec
  );
    cnt_op_e op;
    op = CNT_HOLD;
    unique case (1'b1)
      inc && !dec: op = CNT_INC;
      dec && !inc: op = CNT_DEC;
      default:     op = CNT_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/floo_credit_cnt_slice.sv
// One saturating up/down credit counter for a single downstream VC.
// Ports: clk_i, rst_ni, inc, dec in; count, overflow, underflow out.
module floo_credit_cnt_slice
  import floo_pkg::*;
#(
  parameter int unsigned VCDepth      = 2,
  parameter int unsigned VCDepthWidth = $clog2(VCDepth + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    inc,
  input  logic                    dec,
  output logic [VCDepthWidth-1:0] count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam logic [VCDepthWidth-1:0] Full = VCDepthWidth'(VCDepth);
  localparam logic [VCDepthWidth-1:0] One  = VCDepthWidth'(1);

  cnt_op_e op;
  logic    full;
  logic    empty;

  assign op    = cnt_op(inc, dec);
  assign full  = (count == Full);
  assign empty = (count == '0);

  // Error pulses; the counter itself saturates instead of wrapping.
  assign overflow  = (op == CNT_INC) && full;
  assign underflow = (op == CNT_DEC) && empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= Full;
    end else begin
      unique case (op)
        CNT_INC: if (!full) count <= count + One;
        CNT_DEC: if (!empty) count <= count - One;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/floo_vc_credit_counter.sv
// Per-output-port credit tracker, one counter per downstream VC.
// Ports: credit/consume in; counters, not-full, idle, sticky errors out.
module floo_vc_credit_counter
  import floo_pkg::*;
#(
  parameter int unsigned NumVC        = 4,
  parameter int unsigned NumVCWidth   = NumVC > 1 ? $clog2(NumVC) : 1,
  parameter int unsigned VCDepth      = 2,
  parameter int unsigned VCDepthWidth = $clog2(VCDepth + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumVC-1:0]                    credit_v_i,
  input  logic                                consume_v_i,
  input  logic [NumVCWidth-1:0]               consume_id_i,
  output logic [NumVC-1:0][VCDepthWidth-1:0]  credit_counter_o,
  output logic [NumVC-1:0]                    vc_not_full_o,
  output logic                                all_idle_o,
  output logic                                err_overflow_o,
  output logic                                err_underflow_o
);

  localparam logic [VCDepthWidth-1:0] Full = VCDepthWidth'(VCDepth);

  logic [NumVC-1:0] dec;
  logic [NumVC-1:0] ovf;
  logic [NumVC-1:0] udf;
  logic             bad_id;

  for (genvar v = 0; v < NumVC; v++) begin : g_vc
    if (NumVC == 1) begin : g_single
      assign dec[v] = consume_v_i;
    end else begin : g_multi
      assign dec[v] = consume_v_i &&
                      (consume_id_i == NumVCWidth'(v));
    end

    floo_credit_cnt_slice #(
      .VCDepth      (VCDepth),
      .VCDepthWidth (VCDepthWidth)
    ) i_slice (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .inc       (credit_v_i[v]),
      .dec       (dec[v]),
      .count     (credit_counter_o[v]),
      .overflow  (ovf[v]),
      .underflow (udf[v])
    );

    assign vc_not_full_o[v] = |credit_counter_o[v];
  end

  // Ids past the last VC only exist when NumVC is not a power of two.
  if (NumVC == 1) begin : g_no_bad_id
    assign bad_id = 1'b0;
  end else begin : g_bad_id
    assign bad_id = consume_v_i &&
                    (32'(consume_id_i) >= NumVC);
  end

  always_comb begin
    all_idle_o = 1'b1;
    for (int v = 0; v < NumVC; v++) begin
      all_idle_o &= (credit_counter_o[v] == Full);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_overflow_o  <= 1'b0;
      err_underflow_o <= 1'b0;
    end else begin
      err_overflow_o  <= err_overflow_o | (|ovf);
      err_underflow_o <= err_underflow_o | (|udf) | bad_id;
    end
  end

  a_ovf_sticky : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (|ovf) |=> err_overflow_o
  );

  a_udf_sticky : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    ((|udf) || bad_id) |=> err_underflow_o
  );

endmodule

// File: tb/tb_floo_vc_credit_counter.sv
// Randomised and directed bench for floo_vc_credit_counter.
// Checks the DUT each cycle against a behavioural credit model.
module tb_floo_vc_credit_counter;

  localparam int NV = 4;
  localparam int D  = 2;

  logic             clk;
  logic             rst_n;
  logic [NV-1:0]    credit;
  logic             cv;
  logic [1:0]       cid;
  logic [NV-1:0][1:0] cnt;
  logic [NV-1:0]    nf;
  logic             idle;
  logic             eov;
  logic             eud;

  int n_chk  = 0;
  int n_fail = 0;

  int m_cnt [NV];
  bit m_ov;
  bit m_ud;

  floo_vc_credit_counter #(
    .NumVC   (NV),
    .VCDepth (D)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .credit_v_i       (credit),
    .consume_v_i      (cv),
    .consume_id_i     (cid),
    .credit_counter_o (cnt),
    .vc_not_full_o    (nf),
    .all_idle_o       (idle),
    .err_overflow_o   (eov),
    .err_underflow_o  (eud)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               name, act, exp, $time);
    end
  endtask

  // Model update at each clock edge, then compare against the DUT.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      foreach (m_cnt[v]) m_cnt[v] = D;
      m_ov = 0;
      m_ud = 0;
    end else begin
      foreach (m_cnt[v]) begin
        bit i, d;
        i = credit[v];
        d = cv && (cid == v);
        if (i && !d) begin
          if (m_cnt[v] == D) m_ov = 1;
          else m_cnt[v]++;
        end else if (d && !i) begin
          if (m_cnt[v] == 0) m_ud = 1;
          else m_cnt[v]--;
        end
      end
    end
    begin
      int exp_nf, exp_idle;
      exp_nf   = 0;
      exp_idle = 1;
      foreach (m_cnt[v]) begin
        chk($sformatf("cnt%0d", v), int'(cnt[v]), m_cnt[v]);
        if (m_cnt[v] != 0) exp_nf |= (1 << v);
        if (m_cnt[v] != D) exp_idle = 0;
      end
      chk("not_full", int'(nf), exp_nf);
      chk("all_idle", int'(idle), exp_idle);
      chk("err_ovf", int'(eov), int'(m_ov));
      chk("err_udf", int'(eud), int'(m_ud));
    end
  end

  task automatic drive(input logic [3:0] cr,
                       input logic c, input logic [1:0] id);
    credit = cr;
    cv     = c;
    cid    = id;
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'b0, 1'b0, 2'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_cnt", int'(cnt), 8'haa);
    chk("rst_nf", int'(nf), 4'hf);
    chk("rst_idle", int'(idle), 1);
    chk("rst_err", int'({eov, eud}), 0);

    drive(4'b0, 1'b1, 2'd2);
    tick();
    chk("c2_first", int'(cnt[2]), 1);
    chk("idle_first", int'(idle), 0);
    tick();
    chk("c2_second", int'(cnt[2]), 0);
    chk("nf_second", int'(nf), 4'b1011);

    drive(4'b0100, 1'b1, 2'd2);
    tick();
    chk("c2_both", int'(cnt[2]), 0);
    chk("err_both", int'({eov, eud}), 0);
    drive(4'b0100, 1'b0, 2'd0);
    tick();
    chk("c2_credit", int'(cnt[2]), 1);
    tick();
    chk("c2_full", int'(cnt[2]), 2);

    drive(4'b1111, 1'b0, 2'd0);
    tick();
    chk("ovf_cnt", int'(cnt), 8'haa);
    chk("ovf_set", int'(eov), 1);
    drive(4'b0, 1'b0, 2'd0);
    tick();
    chk("ovf_sticky", int'(eov), 1);

    drive(4'b0, 1'b1, 2'd0);
    tick();
    chk("c0_a", int'(cnt[0]), 1);
    tick();
    chk("c0_b", int'(cnt[0]), 0);
    chk("udf_clear", int'(eud), 0);
    tick();
    chk("c0_c", int'(cnt[0]), 0);
    chk("udf_set", int'(eud), 1);
    chk("others", int'(cnt[3:1]), 6'b101010);

    drive(4'b0, 1'b1, 2'd1);
    tick();
    drive(4'b0, 1'b1, 2'd3);
    tick();
    tick();
    drive(4'b0, 1'b0, 2'd0);
    chk("pre_rst", int'(cnt), 8'b00100100);

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", int'(cnt), 8'haa);
    chk("arst_err", int'({eov, eud}), 0);
    chk("arst_idle", int'(idle), 1);
    tick();
    rst_n = 1'b1;
    tick();

    for (int n = 0; n < 3000; n++) begin
      logic [3:0] cr;
      cr = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      drive(cr, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    drive(4'b0, 1'b0, 2'd0);
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
